// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time byte-stream program loader that holds the CPU until an image is written
// Optional trailing XOR checksum byte and CHK state are enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_FLUSH, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] words_q;
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic        mem_we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        accept;
    logic        restart;
    logic        word_end;
    logic        last_word;
    logic [15:0] len_next;

    assign accept    = in_valid && in_ready;
    assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign word_end  = accept && (state_q == S_DATA) && (cnt_q == 2'd3);
    assign last_word = (words_q + 16'd1) == len_q;
    assign len_next  = {len_q[15:8], in_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (restart) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                if ({1'b0, len_next} > MAX_N) state_d = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
                else if (len_next == 16'd0)   state_d = S_CHK;
`else
                else if (len_next == 16'd0)   state_d = S_DONE;
`endif
                else                          state_d = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_DATA: if (word_end && last_word) state_d = S_CHK;
            S_CHK:  if (accept) state_d = (in_byte == xor_q) ? S_DONE : S_ERROR;
`else
            // FLUSH covers the final write strobe so done never coincides with mem_we
            S_DATA:  if (word_end && last_word) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: in_ready = 1'b1;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            words_q  <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (restart) begin
                words_q <= '0;
                cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                xor_q   <= '0;
`endif
            end
            if (accept && state_q == S_LEN_HI) len_q[15:8] <= in_byte;
            if (accept && state_q == S_LEN_LO) len_q[7:0]  <= in_byte;
            if (accept && state_q == S_DATA) begin
                shift_q <= {shift_q[15:0], in_byte};
                cnt_q   <= cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                xor_q   <= xor_q ^ in_byte;
`endif
            end
            // words_q is the index of the word being completed, so it doubles as the address offset
            if (word_end) begin
                mem_we_q <= 1'b1;
                wdata_q  <= {shift_q, in_byte};
                addr_q   <= BASE_ADDR + {14'd0, words_q, 2'b00};
                words_q  <= words_q + 16'd1;
            end
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a stream-level reference model
module tb_prog_loader;
    localparam int MAXW = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] exp_wl[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        exp_done, exp_err;
    logic [15:0] exp_words;
    int          exp_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: derives writes and final outcome straight from the stream format
    task automatic model();
        int n;
        logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00;
`endif
        n = int'({stim[0], stim[1]});
        exp_done = 1'b0; exp_err = 1'b0; exp_words = 16'd0; exp_lat = 0;
        if (n > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
`ifdef LOADER_CHECKSUM_EN
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
            exp_addr.push_back(BASE + 32'(4*k));
            exp_data.push_back(w);
            exp_wl.push_back(16'(k+1));
        end
        exp_words = 16'(n);
`ifdef LOADER_CHECKSUM_EN
        if (stim[2+4*n] == cs) exp_done = 1'b1;
        else                   exp_err = 1'b1;
`else
        exp_done = 1'b1;
        exp_lat  = (n > 0) ? 1 : 0;
`endif
    endtask

    task automatic append_chk(input bit good);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00;
        for (int i = 2; i < stim.size(); i++) c = c ^ stim[i];
        stim.push_back(good ? c : (c ^ 8'h03));
`else
        if (!good) stim.push_back(8'h00);
`endif
    endtask

    task automatic set_stream1();
        stim = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h00, 8'h05, 8'h20, 8'h12, 8'h00, 8'h13};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        in_byte = b; in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for byte %h, required 1", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    task automatic run(input string tag, input int maxgap, input int mid_start);
        int lat;
        int g;
        lat = -1;
        got_addr.delete(); got_data.delete();
        model();
        pulse_start();
        foreach (stim[i]) begin
            if (i == mid_start) pulse_start();
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            send_byte(stim[i], g);
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (done || error) begin lat = t; break; end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
        check({tag, "_words"}, words_loaded, exp_words);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_writes_outstanding"}, exp_addr.size(), 0);
        exp_addr.delete(); exp_data.delete(); exp_wl.delete();
    endtask

    task automatic check_stream1_literals(input string tag);
        check({tag, "_nwrites"}, got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            check({tag, "_w0_addr"}, got_addr[0], 32'h0000_0000);
            check({tag, "_w0_data"}, got_data[0], 32'h2011_0005);
            check({tag, "_w1_addr"}, got_addr[1], 32'h0000_0004);
            check({tag, "_w1_data"}, got_data[1], 32'h2012_0013);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("hold_vs_done", cpu_hold, !done);
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                check("done_during_we", done, 0);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write", mem_addr, mem_wdata);
                end else begin
                    check("wr_addr", mem_addr, exp_addr.pop_front());
                    check("wr_data", mem_wdata, exp_data.pop_front());
                    check("wr_words", words_loaded, exp_wl.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", cpu_hold, 1);
        check("idle_done", done, 0);

        set_stream1(); append_chk(1'b1);
        run("good", 0, -1);
        check_stream1_literals("good_lit");
        check("good_lit_words", words_loaded, 16'd2);

`ifdef LOADER_CHECKSUM_EN
        set_stream1(); stim.push_back(8'h16);
        run("badchk", 0, -1);
        check_stream1_literals("badchk_lit");
        check("badchk_lit_error", error, 1);
`endif

        stim = '{8'h00, 8'h00}; append_chk(1'b1);
        run("empty", 0, -1);
        check("empty_nwrites", got_addr.size(), 0);

        stim = '{8'h00, 8'h05};
        run("oversize", 0, -1);
        check("oversize_nwrites", got_addr.size(), 0);
        check("oversize_words", words_loaded, 0);

        stim = '{8'h00, 8'h04};
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        append_chk(1'b1);
        run("maxlen", 1, -1);
        check("maxlen_nwrites", got_addr.size(), 4);

        set_stream1(); append_chk(1'b1);
        got_addr.delete(); got_data.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stim[i], int'($urandom_range(0, 3)));
        #2 rst_n = 1'b0;
        #2 check_reset("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_nwrites", got_addr.size(), 0);
        run("restart", 3, -1);
        check_stream1_literals("restart_lit");

        set_stream1(); append_chk(1'b1);
        run("midstart", 0, 4);
        check_stream1_literals("midstart_lit");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
